// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central stall/flush/halt sequencer for the 5-stage pipeline
//            (IF, ID, EX, MEM, WB). It resolves load-use data hazards,
//            taken-branch redirects, multi-cycle memory waits (with a
//            timeout) and HLT drain/halt/resume. Its outputs drive the
//            hold/flush/hlt controls of every pipeline register and the PC.
// Ports    :
//   clk, rst_n          clock, asynchronous active-low reset
//   ID_src1/2, ID_use_* source registers of the ID instruction and whether
//                       each one is actually read
//   ID_halt             ID holds an HLT instruction
//   EX_mem_read         EX instruction is a load
//   EX_use_dst_reg      EX instruction writes EX_dst_reg
//   EX_branch_taken     EX resolved a taken branch/jump
//   MEM_mem_req         MEM instruction accesses memory
//   mem_ready           memory completes the access this cycle
//   resume              external restart pulse (only honoured in HALTED)
//   PC_hold             freeze the PC
//   IF_ID_*, ID_EX_*    hold/flush controls of the front pipeline registers
//   EX_MEM_hold         hold of the EX/MEM register
//   MEM_WB_flush        inject a bubble into WB
//   hlt                 global freeze (decoded from the state register)
//   mem_err             sticky memory-timeout flag
//   state               debug: 0 RUN, 1 DRAIN, 2 HALTED, 3 ERROR
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,   // cycles from HLT acceptance to halt, >= 1
    parameter int MEM_TIMEOUT  = 64   // max consecutive wait cycles, 2..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] ID_src1,
    input  logic [4:0] ID_src2,
    input  logic       ID_use_src1,
    input  logic       ID_use_src2,
    input  logic       ID_halt,
    input  logic       EX_mem_read,
    input  logic       EX_use_dst_reg,
    input  logic [4:0] EX_dst_reg,
    input  logic       EX_branch_taken,
    input  logic       MEM_mem_req,
    input  logic       mem_ready,
    input  logic       resume,
    output logic       PC_hold,
    output logic       IF_ID_hold,
    output logic       IF_ID_flush,
    output logic       ID_EX_hold,
    output logic       ID_EX_flush,
    output logic       EX_MEM_hold,
    output logic       MEM_WB_flush,
    output logic       hlt,
    output logic       mem_err,
    output logic [1:0] state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [DW-1:0] c_DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [7:0]    c_WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q,     state_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [7:0]      wait_cnt_q,  wait_cnt_d;
    logic            mem_err_q,   mem_err_d;

    // ------------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------------
    logic w_memstall;
    logic w_loaduse;
    logic w_src1_hit;
    logic w_src2_hit;

    assign w_memstall = MEM_mem_req & ~mem_ready;
    assign w_src1_hit = ID_use_src1 & (ID_src1 == EX_dst_reg);
    assign w_src2_hit = ID_use_src2 & (ID_src2 == EX_dst_reg);
    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_loaduse  = EX_mem_read & EX_use_dst_reg & (EX_dst_reg != 5'd0) &
                        (w_src1_hit | w_src2_hit);

    // Raw (ungated) control outputs from the next-state process
    logic w_pc_hold;
    logic w_if_id_hold;
    logic w_if_id_flush;
    logic w_id_ex_hold;
    logic w_id_ex_flush;
    logic w_ex_mem_hold;
    logic w_mem_wb_flush;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            drain_cnt_q <= '0;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        wait_cnt_d     = 8'd0;          // any cycle without a stall clears it
        mem_err_d      = mem_err_q;
        w_pc_hold      = 1'b0;
        w_if_id_hold   = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_hold   = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_hold  = 1'b0;
        w_mem_wb_flush = 1'b0;

        case (state_q)
            S_RUN, S_DRAIN: begin
                if (w_memstall) begin
                    // Freeze everything up to MEM and bubble WB. All other
                    // hazards are re-evaluated once memory is ready.
                    w_pc_hold      = 1'b1;
                    w_if_id_hold   = 1'b1;
                    w_id_ex_hold   = 1'b1;
                    w_ex_mem_hold  = 1'b1;
                    w_mem_wb_flush = 1'b1;
                    if (wait_cnt_q == c_WAIT_LAST) begin
                        state_d   = S_ERROR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else if (state_q == S_DRAIN) begin
                    // Keep the HLT parked in IF/ID while EX/MEM/WB empty out.
                    // A branch cannot appear here since EX only sees bubbles.
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_id_ex_flush = 1'b1;
                    if (drain_cnt_q == '0) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                    end
                end else if (EX_branch_taken) begin
                    // Squashes whatever is in IF and ID, including an HLT.
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (ID_halt) begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_id_ex_flush = 1'b1;
                    state_d       = S_DRAIN;
                    drain_cnt_d   = c_DRAIN_LOAD;
                end else if (w_loaduse) begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end

            S_HALTED: begin
                if (resume) begin
                    // Release the PC and drop the parked HLT from IF/ID.
                    w_if_id_flush = 1'b1;
                    state_d       = S_RUN;
                end else begin
                    w_pc_hold    = 1'b1;
                    w_if_id_hold = 1'b1;
                end
            end

            S_ERROR: begin
                // Terminal until reset; resume is deliberately ignored.
                w_pc_hold    = 1'b1;
                w_if_id_hold = 1'b1;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: controls are forced low for as long as reset is applied
    // ------------------------------------------------------------------------
    assign PC_hold      = rst_n & w_pc_hold;
    assign IF_ID_hold   = rst_n & w_if_id_hold;
    assign IF_ID_flush  = rst_n & w_if_id_flush;
    assign ID_EX_hold   = rst_n & w_id_ex_hold;
    assign ID_EX_flush  = rst_n & w_id_ex_flush;
    assign EX_MEM_hold  = rst_n & w_ex_mem_hold;
    assign MEM_WB_flush = rst_n & w_mem_wb_flush;
    // Decoded straight from the register so the freeze line cannot glitch.
    assign hlt          = (state_q == S_HALTED) | (state_q == S_ERROR);
    assign mem_err      = mem_err_q;
    assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl. Two DUTs share
//            the stimulus: u_dut uses the default timeout, u_dut_to uses a
//            timeout of 4 and has its own reset, released only for the
//            timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    // Observed vector layout:
    // {PC_hold, IF_ID_hold, IF_ID_flush, ID_EX_hold, ID_EX_flush,
    //  EX_MEM_hold, MEM_WB_flush, hlt, mem_err, state[1:0]}
    localparam logic [10:0] c_IDLE     = 11'b0_0_0_0_0_0_0_0_0_00;
    localparam logic [10:0] c_BUBBLE   = 11'b1_1_0_0_1_0_0_0_0_00;
    localparam logic [10:0] c_BRANCH   = 11'b0_0_1_0_1_0_0_0_0_00;
    localparam logic [10:0] c_MS_RUN   = 11'b1_1_0_1_0_1_1_0_0_00;
    localparam logic [10:0] c_DRAIN    = 11'b1_1_0_0_1_0_0_0_0_01;
    localparam logic [10:0] c_MS_DRAIN = 11'b1_1_0_1_0_1_1_0_0_01;
    localparam logic [10:0] c_HALTED   = 11'b1_1_0_0_0_0_0_1_0_10;
    localparam logic [10:0] c_RESUME   = 11'b0_0_1_0_0_0_0_1_0_10;
    localparam logic [10:0] c_ERROR    = 11'b1_1_0_0_0_0_0_1_1_11;

    logic       clk;
    logic       rst_n;
    logic       rst_to_n;
    logic [4:0] ID_src1, ID_src2;
    logic       ID_use_src1, ID_use_src2, ID_halt;
    logic       EX_mem_read, EX_use_dst_reg;
    logic [4:0] EX_dst_reg;
    logic       EX_branch_taken, MEM_mem_req, mem_ready, resume;

    logic       a_pc_hold, a_ifid_hold, a_ifid_flush, a_idex_hold, a_idex_flush;
    logic       a_exmem_hold, a_memwb_flush, a_hlt, a_mem_err;
    logic [1:0] a_state;
    logic       b_pc_hold, b_ifid_hold, b_ifid_flush, b_idex_hold, b_idex_flush;
    logic       b_exmem_hold, b_memwb_flush, b_hlt, b_mem_err;
    logic [1:0] b_state;

    logic [10:0] obs_a, obs_b;
    assign obs_a = {a_pc_hold, a_ifid_hold, a_ifid_flush, a_idex_hold, a_idex_flush,
                    a_exmem_hold, a_memwb_flush, a_hlt, a_mem_err, a_state};
    assign obs_b = {b_pc_hold, b_ifid_hold, b_ifid_flush, b_idex_hold, b_idex_flush,
                    b_exmem_hold, b_memwb_flush, b_hlt, b_mem_err, b_state};

    int vectors = 0;
    int errors  = 0;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(64)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ID_src1(ID_src1), .ID_src2(ID_src2),
        .ID_use_src1(ID_use_src1), .ID_use_src2(ID_use_src2), .ID_halt(ID_halt),
        .EX_mem_read(EX_mem_read), .EX_use_dst_reg(EX_use_dst_reg),
        .EX_dst_reg(EX_dst_reg), .EX_branch_taken(EX_branch_taken),
        .MEM_mem_req(MEM_mem_req), .mem_ready(mem_ready), .resume(resume),
        .PC_hold(a_pc_hold), .IF_ID_hold(a_ifid_hold), .IF_ID_flush(a_ifid_flush),
        .ID_EX_hold(a_idex_hold), .ID_EX_flush(a_idex_flush),
        .EX_MEM_hold(a_exmem_hold), .MEM_WB_flush(a_memwb_flush),
        .hlt(a_hlt), .mem_err(a_mem_err), .state(a_state)
    );

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst_n(rst_to_n),
        .ID_src1(ID_src1), .ID_src2(ID_src2),
        .ID_use_src1(ID_use_src1), .ID_use_src2(ID_use_src2), .ID_halt(ID_halt),
        .EX_mem_read(EX_mem_read), .EX_use_dst_reg(EX_use_dst_reg),
        .EX_dst_reg(EX_dst_reg), .EX_branch_taken(EX_branch_taken),
        .MEM_mem_req(MEM_mem_req), .mem_ready(mem_ready), .resume(resume),
        .PC_hold(b_pc_hold), .IF_ID_hold(b_ifid_hold), .IF_ID_flush(b_ifid_flush),
        .ID_EX_hold(b_idex_hold), .ID_EX_flush(b_idex_flush),
        .EX_MEM_hold(b_exmem_hold), .MEM_WB_flush(b_memwb_flush),
        .hlt(b_hlt), .mem_err(b_mem_err), .state(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_src1 = 5'd0; ID_src2 = 5'd0; ID_use_src1 = 1'b0; ID_use_src2 = 1'b0;
        ID_halt = 1'b0; EX_mem_read = 1'b0; EX_use_dst_reg = 1'b0;
        EX_dst_reg = 5'd0; EX_branch_taken = 1'b0; MEM_mem_req = 1'b0;
        mem_ready = 1'b1; resume = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0; rst_to_n = 1'b0;
        // Hazard stimulus present during reset must not leak to the outputs.
        EX_mem_read = 1'b1; EX_use_dst_reg = 1'b1; EX_dst_reg = 5'd7;
        ID_src1 = 5'd7; ID_use_src1 = 1'b1; MEM_mem_req = 1'b1; mem_ready = 1'b0;
        #3;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL reset_hold got %b want %b", obs_a, c_IDLE);
        end
        step(); step();
        vectors++;
        if (obs_b !== c_IDLE) begin
            errors++; $display("FAIL reset_to_hold got %b want %b", obs_b, c_IDLE);
        end
        clear_inputs();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL reset_release got %b want %b", obs_a, c_IDLE);
        end
        step();
    endtask

    task automatic test_load_use();
        EX_mem_read = 1'b1; EX_use_dst_reg = 1'b1; EX_dst_reg = 5'd5;
        ID_src2 = 5'd5; ID_use_src2 = 1'b1;
        #1;
        vectors++;
        if (obs_a !== c_BUBBLE) begin
            errors++; $display("FAIL load_use got %b want %b", obs_a, c_BUBBLE);
        end
        step();
        clear_inputs();
        #1;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL load_use_after got %b want %b", obs_a, c_IDLE);
        end
        // Destination r0 never stalls.
        EX_mem_read = 1'b1; EX_use_dst_reg = 1'b1; EX_dst_reg = 5'd0;
        ID_src2 = 5'd0; ID_use_src2 = 1'b1;
        #1;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL load_use_r0 got %b want %b", obs_a, c_IDLE);
        end
        // Matching src1 that is not actually read never stalls.
        EX_dst_reg = 5'd9; ID_src1 = 5'd9; ID_use_src1 = 1'b0;
        ID_src2 = 5'd3; ID_use_src2 = 1'b1;
        #1;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL load_use_unused got %b want %b", obs_a, c_IDLE);
        end
        // Same match on src1 once it is read.
        ID_use_src1 = 1'b1;
        #1;
        vectors++;
        if (obs_a !== c_BUBBLE) begin
            errors++; $display("FAIL load_use_src1 got %b want %b", obs_a, c_BUBBLE);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_branch_vs_halt();
        EX_branch_taken = 1'b1; ID_halt = 1'b1;
        #1;
        vectors++;
        if (obs_a !== c_BRANCH) begin
            errors++; $display("FAIL branch_halt got %b want %b", obs_a, c_BRANCH);
        end
        step();
        clear_inputs();
        #1;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL branch_halt_state got %b want %b", obs_a, c_IDLE);
        end
    endtask

    task automatic test_mem_wait();
        MEM_mem_req = 1'b1; mem_ready = 1'b0;
        EX_branch_taken = 1'b1;               // ignored under a memory stall
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (obs_a !== c_MS_RUN) begin
                errors++; $display("FAIL mem_wait[%0d] got %b want %b", i, obs_a, c_MS_RUN);
            end
            step();
            EX_branch_taken = 1'b0;
        end
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL mem_ready got %b want %b", obs_a, c_IDLE);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_halt_resume();
        resume = 1'b1;                        // no effect in RUN
        #1;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL resume_in_run got %b want %b", obs_a, c_IDLE);
        end
        step();
        resume = 1'b0;
        ID_halt = 1'b1;
        #1;
        vectors++;
        if (obs_a !== c_BUBBLE) begin
            errors++; $display("FAIL halt_accept got %b want %b", obs_a, c_BUBBLE);
        end
        step();
        ID_halt = 1'b0;
        EX_branch_taken = 1'b1;               // ignored in DRAIN
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (obs_a !== c_DRAIN) begin
                errors++; $display("FAIL drain[%0d] got %b want %b", i, obs_a, c_DRAIN);
            end
            step();
            EX_branch_taken = 1'b0;
        end
        #1;
        vectors++;
        if (obs_a !== c_HALTED) begin
            errors++; $display("FAIL halted got %b want %b", obs_a, c_HALTED);
        end
        step();
        vectors++;
        if (obs_a !== c_HALTED) begin
            errors++; $display("FAIL halted_stay got %b want %b", obs_a, c_HALTED);
        end
        resume = 1'b1;
        #1;
        vectors++;
        if (obs_a !== c_RESUME) begin
            errors++; $display("FAIL resume_cycle got %b want %b", obs_a, c_RESUME);
        end
        step();
        resume = 1'b0;
        #1;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL resumed got %b want %b", obs_a, c_IDLE);
        end
    endtask

    task automatic test_halt_memstall();
        logic [10:0] exp_seq [5];
        exp_seq[0] = c_DRAIN; exp_seq[1] = c_MS_DRAIN; exp_seq[2] = c_MS_DRAIN;
        exp_seq[3] = c_DRAIN; exp_seq[4] = c_DRAIN;
        ID_halt = 1'b1;
        step();
        ID_halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            MEM_mem_req = (i == 1 || i == 2);
            mem_ready   = 1'b0;
            #1;
            vectors++;
            if (obs_a !== exp_seq[i]) begin
                errors++; $display("FAIL drain_ms[%0d] got %b want %b", i, obs_a, exp_seq[i]);
            end
            step();
        end
        clear_inputs();
        #1;
        vectors++;
        if (obs_a !== c_HALTED) begin
            errors++; $display("FAIL drain_ms_halted got %b want %b", obs_a, c_HALTED);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        #1;
        vectors++;
        if (obs_a !== c_IDLE) begin
            errors++; $display("FAIL drain_ms_resumed got %b want %b", obs_a, c_IDLE);
        end
    endtask

    task automatic test_timeout();
        rst_to_n = 1'b1;
        step();
        // Two 3-cycle waits split by a ready cycle must not time out.
        for (int i = 0; i < 7; i++) begin
            MEM_mem_req = 1'b1;
            mem_ready   = (i == 3);
            #1;
            vectors++;
            if (obs_b !== ((i == 3) ? c_IDLE : c_MS_RUN)) begin
                errors++;
                $display("FAIL wait_clear[%0d] got %b want %b", i, obs_b,
                         (i == 3) ? c_IDLE : c_MS_RUN);
            end
            step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (obs_b !== c_MS_RUN) begin
                errors++; $display("FAIL timeout_wait[%0d] got %b want %b", i, obs_b, c_MS_RUN);
            end
            step();
        end
        #1;
        vectors++;
        if (obs_b !== c_ERROR) begin
            errors++; $display("FAIL timeout_error got %b want %b", obs_b, c_ERROR);
        end
        resume = 1'b1; mem_ready = 1'b1;
        step();
        step();
        vectors++;
        if (obs_b !== c_ERROR) begin
            errors++; $display("FAIL error_resume got %b want %b", obs_b, c_ERROR);
        end
        resume = 1'b0;
        mem_ready = 1'b0;
        #2;
        rst_to_n = 1'b0;
        #1;
        vectors++;
        if (obs_b !== c_IDLE) begin
            errors++; $display("FAIL error_reset got %b want %b", obs_b, c_IDLE);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_halt();
        test_mem_wait();
        test_halt_resume();
        test_halt_memstall();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
